uart_apb_poller: RTL and testbench
==================================

# uart_apb_poller

APB initiator that owns the 8-bit APB bus of the CoreUARTapb-based UART block and turns it into two byte streams. After reset it programs the UART control registers, then polls the status register. It drains received bytes into `rx_*` and pushes `tx_*` bytes into the UART transmit register. It sits between the UART APB port and the bridge datapath, so the bridge logic never handles APB directly.

## Interface
- `BAUD_VALUE`, 1: 13-bit baud divisor. Bits [7:0] go to CTRL1; bits [12:8] go to CTRL2[7:3].
- `BIT8`, 1: CTRL2[0], 8-bit data mode.
- `PARITY_EN`, 0: CTRL2[1].
- `PARITY_ODD`, 0: CTRL2[2].
- `POLL_GAP`, 4: number of idle cycles (PSEL=0) between status polls when no work was found. 0 is legal.
- `PCLK` in 1: single clock.
- `PRESETN` in 1: asynchronous, active-low reset.
- `PADDR` out 5: APB address.
- `PSEL` out 1: APB select.
- `PENABLE` out 1: APB enable.
- `PWRITE` out 1: APB direction.
- `PWDATA` out 8: APB write data.
- `PRDATA` in 8: APB read data.
- `PREADY` in 1: APB ready.
- `PSLVERR` in 1: APB error.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: byte held in `rx_data`.
- `rx_ready` in 1: consumer accepts the held byte.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: byte offered.
- `tx_ready` out 1: one-cycle pulse; the offered byte was written to the UART.
- `init_done` out 1: set once both control writes have completed.
- `slverr` out 1: one-cycle pulse on any transfer completing with PSLVERR=1.
- `err_parity`, `err_overflow`, `err_framing` out 8 each: saturating error counters (see Configuration).

## Operation
- UART register map:
  - TXDATA 0x00
  - RXDATA 0x04
  - CTRL1 0x08
  - CTRL2 0x0C
  - STATUS 0x10
- STATUS bits:
  - [0] TXRDY
  - [1] RXRDY
  - [2] PARITY_ERR
  - [3] OVERFLOW
  - [4] FRAMING_ERR
- FSM states:
  - INIT1_S, INIT1_A: write CTRL1.
  - INIT2_S, INIT2_A: write CTRL2.
  - ST_S, ST_A: read STATUS.
  - RX_S, RX_A: read RXDATA.
  - TX_S, TX_A: write TXDATA.
  - GAP: idle between polls.
- *_S states (APB setup):
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA are registered on entry.
  - Always lasts exactly one cycle.
- *_A states (APB access):
  - PSEL=1, PENABLE=1.
  - Held until PREADY=1; all outputs stay stable while waiting.
- Flow: reset release → INIT1_S → INIT1_A → INIT2_S → INIT2_A → `init_done`=1 → ST_S.
- Decision on ST_A completion, evaluated using the PRDATA just read, in priority order:
  - RXRDY=1 and `rx_valid`=0 → RX_S.
  - Else TXRDY=1 and `tx_valid`=1 → TX_S.
  - Else GAP, or ST_S directly if POLL_GAP=0.
- RX_A and TX_A completion → ST_S, with no gap.
- RX_A completion, PSLVERR=0: `rx_data`←PRDATA and `rx_valid`←1 next cycle.
- RX_A completion, PSLVERR=1: byte is discarded and `slverr` pulses.
- `rx_valid` clears on the cycle after `rx_valid`&`rx_ready`. A full holding register stalls RX reads; the UART FIFO absorbs the backpressure and may overflow.
- `tx_data` is captured into PWDATA on entry to TX_S. `tx_ready` pulses in the cycle TX_A completes, regardless of PSLVERR.
- Reset asserted mid-transfer:
  - All state clears immediately.
  - INIT re-runs after release.
  - A pending `tx_valid` byte is not consumed.

## Timing
- Reset values:
  - PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA = 0.
  - `rx_valid`, `rx_data` = 0.
  - `tx_ready`, `init_done`, `slverr` = 0.
  - All counters = 0.
- Zero-wait APB: every transfer takes 2 cycles.
- RX path, zero-wait: ST_S at cycle n, then RX_S at n+2, RX_A at n+3, `rx_valid`=1 at n+4.
- TX path, zero-wait: ST_S at n, then TX_S at n+2, `tx_ready` pulse at n+3.
- Each PREADY=0 cycle adds one cycle to the transfer it occurs in.
- Idle poll period: 2 + POLL_GAP cycles.

## Configuration
- `UART_POLL_ERR_CNT_EN` defined:
  - On each ST_A completion, each of STATUS[2], [3] and [4] that is set increments its own 8-bit counter.
  - Counters saturate at 255.
- Undefined: the counter ports remain and are tied to 0; no counter logic is built.

## Structure
- Package `uart_poll_pkg` holds:
  - the register address constants;
  - the STATUS bit indices;
  - the FSM state enum.
- Sub-module `apb_xfer_engine` runs one APB transfer.
  - Inputs: start, addr, write, wdata.
  - Outputs: done, rdata, err.
  - It owns the S/A sequencing; the top FSM only sequences transfers.

## Test plan
- Reset release with zero-wait PREADY, BAUD_VALUE=0x123 → write 0x23 to 0x08, then 0x08 to 0x0C (BIT8=0), `init_done`=1, then a read of 0x10.
- STATUS=0x02 with RXDATA=0xA5 and `rx_ready`=0 → `rx_valid`=1 with 0xA5 at n+4. Later polls never read 0x04 until the byte is accepted.
- STATUS=0x03 with `tx_valid`=1, data 0x5A, `rx_valid`=0 → RX read is issued before the TX write. 0x5A is written to 0x00 on the second pass, and `tx_ready` pulses once.
- PREADY held low for 3 cycles during TX_A → PSEL, PENABLE, PADDR and PWDATA stable throughout; `tx_ready` pulses only on the PREADY=1 cycle.
- PSLVERR=1 on an RX read → `slverr` pulses and `rx_valid` stays 0.
- With `UART_POLL_ERR_CNT_EN` defined, STATUS=0x1C for 300 polls → all three counters read 255.

Source files
------------

// File: rtl/uart_poll_pkg.sv
// Shared definitions for the UART APB poller: register map, STATUS bit
// positions and the poller FSM state encoding.
package uart_poll_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam int STAT_TXRDY    = 0;
  localparam int STAT_RXRDY    = 1;
  localparam int STAT_PARITY   = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_FRAMING  = 4;

  typedef enum logic [3:0] {
    INIT1_S, INIT1_A,
    INIT2_S, INIT2_A,
    ST_S,    ST_A,
    RX_S,    RX_A,
    TX_S,    TX_A,
    GAP
  } poll_state_t;

  // Setup states are the ones whose entry launches a new APB transfer.
  function automatic logic is_setup(input poll_state_t s);
    return s inside {INIT1_S, INIT2_S, ST_S, RX_S, TX_S};
  endfunction

endpackage

// File: rtl/uart_apb_poller_if.sv
// 8-bit APB bus between the poller (master) and the CoreUARTapb port (slave).
interface uart_apb_poller_if;
  logic [4:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_xfer_engine.sv
// Runs one APB transfer at a time: setup for one cycle, access until PREADY.
// A new start is accepted while idle or in the completion cycle (back-to-back).
module apb_xfer_engine (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  start,
  input  logic [4:0]            addr,
  input  logic                  write,
  input  logic [7:0]            wdata,
  output logic                  done,
  output logic [7:0]            rdata,
  output logic                  err,
  uart_apb_poller_if.master     apb
);

  assign done  = apb.PSEL & apb.PENABLE & apb.PREADY;
  assign rdata = apb.PRDATA;
  assign err   = done & apb.PSLVERR;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWRITE  <= 1'b0;
      apb.PWDATA  <= '0;
    end else if (!apb.PSEL || done) begin
      apb.PENABLE <= 1'b0;
      apb.PSEL    <= start;
      if (start) begin
        apb.PADDR  <= addr;
        apb.PWRITE <= write;
        apb.PWDATA <= wdata;
      end
    end else if (!apb.PENABLE) begin
      apb.PENABLE <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_apb_poller.sv
// APB poller for the CoreUARTapb UART: programs CTRL1/CTRL2, then polls STATUS
// to move bytes between the UART and rx_*/tx_* streams. Optional error
// counters are built only when UART_POLL_ERR_CNT_EN is defined.
module uart_apb_poller
  import uart_poll_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic        BIT8       = 1'b1,
  parameter logic        PARITY_EN  = 1'b0,
  parameter logic        PARITY_ODD = 1'b0,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  uart_apb_poller_if.master apb,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              init_done,
  output logic              slverr,
  output logic [7:0]        err_parity,
  output logic [7:0]        err_overflow,
  output logic [7:0]        err_framing
);

  localparam logic [7:0]  CTRL2_VAL = {BAUD_VALUE[12:8], PARITY_ODD, PARITY_EN, BIT8};
  localparam logic [15:0] GAP_LOAD  = 16'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

  poll_state_t state, nxt;
  logic [15:0] gap_cnt;
  logic        start, write, done, err;
  logic [4:0]  addr;
  logic [7:0]  wdata, rdata;

  apb_xfer_engine u_xfer (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .start   (start),
    .addr    (addr),
    .write   (write),
    .wdata   (wdata),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .apb     (apb)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nxt = state;
    unique case (state)
      GAP:     if (!init_done) nxt = INIT1_S;
               else if (gap_cnt == '0) nxt = ST_S;
      INIT1_S: nxt = INIT1_A;
      INIT1_A: if (done) nxt = INIT2_S;
      INIT2_S: nxt = INIT2_A;
      INIT2_A: if (done) nxt = ST_S;
      ST_S:    nxt = ST_A;
      ST_A:    if (done) begin
                 if (rdata[STAT_RXRDY] && !rx_valid)     nxt = RX_S;
                 else if (rdata[STAT_TXRDY] && tx_valid) nxt = TX_S;
                 else if (POLL_GAP == 0)                 nxt = ST_S;
                 else                                    nxt = GAP;
               end
      RX_S:    nxt = RX_A;
      RX_A:    if (done) nxt = ST_S;
      TX_S:    nxt = TX_A;
      TX_A:    if (done) nxt = ST_S;
      default: nxt = GAP;
    endcase
  end

  // The transfer is described by the state being entered, so the engine can
  // launch it in the same edge the previous one completes.
  always_comb begin
    start = is_setup(nxt);
    addr  = ADDR_STATUS;
    write = 1'b0;
    wdata = '0;
    unique case (nxt)
      INIT1_S: begin addr = ADDR_CTRL1;  write = 1'b1; wdata = BAUD_VALUE[7:0]; end
      INIT2_S: begin addr = ADDR_CTRL2;  write = 1'b1; wdata = CTRL2_VAL;       end
      RX_S:    addr = ADDR_RXDATA;
      TX_S:    begin addr = ADDR_TXDATA; write = 1'b1; wdata = tx_data;         end
      default: ;
    endcase
  end

  assign tx_ready = (state == TX_A) && done;

  // GAP doubles as the post-reset idle state; it exits to INIT1_S until init completes.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= GAP;
      gap_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      init_done <= 1'b0;
      slverr    <= 1'b0;
    end else begin
      state  <= nxt;
      slverr <= err;

      if (state == ST_A && nxt == GAP)     gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;

      if (state == INIT2_A && done) init_done <= 1'b1;

      // RX reads are only issued with the holding register empty, so load and clear never collide.
      if (state == RX_A && done && !err) begin
        rx_data  <= rdata;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_POLL_ERR_CNT_EN
  logic st_done;
  assign st_done = (state == ST_A) && done;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      err_parity   <= '0;
      err_overflow <= '0;
      err_framing  <= '0;
    end else if (st_done) begin
      if (rdata[STAT_PARITY]   && err_parity   != 8'hFF) err_parity   <= err_parity   + 8'd1;
      if (rdata[STAT_OVERFLOW] && err_overflow != 8'hFF) err_overflow <= err_overflow + 8'd1;
      if (rdata[STAT_FRAMING]  && err_framing  != 8'hFF) err_framing  <= err_framing  + 8'd1;
    end
  end
`else
  assign err_parity   = '0;
  assign err_overflow = '0;
  assign err_framing  = '0;
`endif

endmodule

// File: tb/tb_uart_apb_poller.sv
// Directed bench for uart_apb_poller: a small UART register model answers APB
// reads, a monitor logs completed transfers, and directed vectors are checked.
module tb_uart_apb_poller;
  import uart_poll_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
  logic       init_done, slverr;
  logic [7:0] err_parity, err_overflow, err_framing;

  logic [7:0] status_reg, rxbyte;
  logic       pready, pslverr;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] q_addr[$];
  logic       q_wr[$];
  logic [7:0] q_dat[$];
  int tx_pulses = 0;
  int st_reads  = 0;
  int rx_reads  = 0;

  uart_apb_poller_if apb();

  assign apb.PRDATA  = (apb.PADDR == ADDR_STATUS) ? status_reg :
                       (apb.PADDR == ADDR_RXDATA) ? rxbyte : 8'h00;
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pslverr;

  uart_apb_poller #(
    .BAUD_VALUE (13'h123),
    .BIT8       (1'b0),
    .PARITY_EN  (1'b0),
    .PARITY_ODD (1'b0),
    .POLL_GAP   (4)
  ) dut (
    .PCLK         (clk),
    .PRESETN      (rst_n),
    .apb          (apb),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .init_done    (init_done),
    .slverr       (slverr),
    .err_parity   (err_parity),
    .err_overflow (err_overflow),
    .err_framing  (err_framing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
      q_addr.push_back(apb.PADDR);
      q_wr.push_back(apb.PWRITE);
      q_dat.push_back(apb.PWRITE ? apb.PWDATA : apb.PRDATA);
      if (!apb.PWRITE && apb.PADDR == ADDR_STATUS) st_reads++;
      if (!apb.PWRITE && apb.PADDR == ADDR_RXDATA) rx_reads++;
    end
    if (tx_ready) tx_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for a setup (en=0) or access (en=1) cycle at address a.
  task automatic wait_phase(input string tag, input logic [4:0] a, input logic en, input logic wr);
    logic found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = apb.PSEL && (apb.PENABLE == en) && (apb.PADDR == a) && (apb.PWRITE == wr);
    end
    check(tag, found, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = !apb.PSEL;
    end
    check(tag, found, 1'b1);
  endtask

  task automatic wait_tx(input string tag, input int base);
    logic found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = (tx_pulses != base);
    end
    check(tag, found, 1'b1);
  endtask

  task automatic drain_rx;
    wait_idle("drain_idle");
    status_reg = 8'h00;
    rx_ready   = 1'b1;
    @(negedge clk);
    check("drain_rx_valid", rx_valid, 1'b0);
    rx_ready   = 1'b0;
  endtask

  initial begin
    int qb, txp0, rxr0, st0;
    logic found;
    status_reg = 8'h00; rxbyte = 8'h00; pready = 1'b1; pslverr = 1'b0;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_psel",     apb.PSEL,    1'b0);
    check("rst_penable",  apb.PENABLE, 1'b0);
    check("rst_pwrite",   apb.PWRITE,  1'b0);
    check("rst_paddr",    apb.PADDR,   5'h00);
    check("rst_pwdata",   apb.PWDATA,  8'h00);
    check("rst_rx_valid", rx_valid,    1'b0);
    check("rst_rx_data",  rx_data,     8'h00);
    check("rst_tx_ready", tx_ready,    1'b0);
    check("rst_init",     init_done,   1'b0);
    check("rst_slverr",   slverr,      1'b0);
    check("rst_cnt",      {err_parity, err_overflow, err_framing}, 24'h0);

    // Init sequence: CTRL1=0x23, CTRL2=0x08, then a STATUS read
    rst_n = 1'b1;
    @(negedge clk);
    check("init_first_setup", {apb.PSEL, apb.PENABLE, apb.PADDR}, {2'b10, ADDR_CTRL1});
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = (q_addr.size() >= 3);
    end
    check("init_wait", found, 1'b1);
    if (found) begin
      check("init_w1", {q_addr[0], q_wr[0], q_dat[0]}, {ADDR_CTRL1, 1'b1, 8'h23});
      check("init_w2", {q_addr[1], q_wr[1], q_dat[1]}, {ADDR_CTRL2, 1'b1, 8'h08});
      check("init_st", {q_addr[2], q_wr[2]}, {ADDR_STATUS, 1'b0});
    end
    check("init_done", init_done, 1'b1);

    // RX path timing: ST_S at n, RX_S at n+2, RX_A at n+3, rx_valid at n+4
    wait_idle("rx_idle");
    status_reg = 8'h02; rxbyte = 8'hA5;
    wait_phase("rx_st_s", ADDR_STATUS, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rx_s_n2", {apb.PSEL, apb.PENABLE, apb.PADDR, apb.PWRITE}, {2'b10, ADDR_RXDATA, 1'b0});
    @(negedge clk);
    check("rx_a_n3", {apb.PSEL, apb.PENABLE, apb.PADDR}, {2'b11, ADDR_RXDATA});
    check("rx_valid_n3", rx_valid, 1'b0);
    @(negedge clk);
    check("rx_valid_n4", rx_valid, 1'b1);
    check("rx_data_n4",  rx_data,  8'hA5);
    rxr0 = rx_reads;
    repeat (30) @(negedge clk);
    check("rx_stall_no_read", rx_reads - rxr0, 0);
    check("rx_held", {rx_valid, rx_data}, {1'b1, 8'hA5});
    drain_rx();

    // RX has priority over TX; TX goes out on the next pass
    wait_idle("tx_idle");
    qb = q_addr.size(); txp0 = tx_pulses;
    status_reg = 8'h03; rxbyte = 8'h3C; tx_data = 8'h5A; tx_valid = 1'b1;
    wait_tx("tx_wait", txp0);
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("tx_pulse_once", tx_pulses - txp0, 1);
    if (q_addr.size() >= qb + 4) begin
      check("tx_seq0", {q_addr[qb],   q_wr[qb],   q_dat[qb]},   {ADDR_STATUS, 1'b0, 8'h03});
      check("tx_seq1", {q_addr[qb+1], q_wr[qb+1], q_dat[qb+1]}, {ADDR_RXDATA, 1'b0, 8'h3C});
      check("tx_seq2", {q_addr[qb+2], q_wr[qb+2]},              {ADDR_STATUS, 1'b0});
      check("tx_seq3", {q_addr[qb+3], q_wr[qb+3], q_dat[qb+3]}, {ADDR_TXDATA, 1'b1, 8'h5A});
    end else begin
      check("tx_seq_len", q_addr.size() - qb, 4);
    end
    check("tx_rx_data", rx_data, 8'h3C);
    drain_rx();

    // PREADY low for 3 cycles during TX_A
    wait_idle("stall_idle");
    txp0 = tx_pulses;
    status_reg = 8'h01; tx_data = 8'hC3; tx_valid = 1'b1;
    wait_phase("stall_tx_s", ADDR_TXDATA, 1'b0, 1'b1);
    pready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_bus%0d", i), {apb.PSEL, apb.PENABLE, apb.PADDR, apb.PWDATA},
            {2'b11, ADDR_TXDATA, 8'hC3});
      check($sformatf("stall_txr%0d", i), tx_ready, 1'b0);
    end
    pready = 1'b1;
    #1;
    check("stall_txr_ready", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0; status_reg = 8'h00;
    check("stall_pulses", tx_pulses - txp0, 1);

    // PSLVERR on an RX read
    wait_idle("err_idle");
    status_reg = 8'h02; rxbyte = 8'h77;
    wait_phase("err_rx_s", ADDR_RXDATA, 1'b0, 1'b0);
    pslverr = 1'b1;
    @(negedge clk);
    check("err_slverr_pre", slverr, 1'b0);
    @(negedge clk);
    check("err_slverr", slverr, 1'b1);
    check("err_rx_valid", rx_valid, 1'b0);
    pslverr = 1'b0; status_reg = 8'h00;
    @(negedge clk);
    check("err_slverr_pulse", slverr, 1'b0);

    // Reset in the middle of a stalled TX transfer
    wait_idle("rst_idle");
    txp0 = tx_pulses;
    status_reg = 8'h01; tx_data = 8'h99; tx_valid = 1'b1;
    wait_phase("rst_tx_s", ADDR_TXDATA, 1'b0, 1'b1);
    pready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus", {apb.PSEL, apb.PENABLE}, 2'b00);
    check("mid_rst_init", init_done, 1'b0);
    check("mid_rst_txr", tx_ready, 1'b0);
    qb = q_addr.size();
    @(negedge clk);
    pready = 1'b1; rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = (q_addr.size() > qb);
    end
    check("mid_rst_reinit_wait", found, 1'b1);
    if (found) check("mid_rst_reinit", {q_addr[qb], q_wr[qb], q_dat[qb]}, {ADDR_CTRL1, 1'b1, 8'h23});
    check("mid_rst_not_consumed", tx_pulses - txp0, 0);
    wait_tx("mid_rst_tx_after", txp0);
    tx_valid = 1'b0; status_reg = 8'h00;

    // Error counters: STATUS=0x1C for 300 polls
    wait_idle("cnt_idle");
    st0 = st_reads;
    status_reg = 8'h1C;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      found = (st_reads - st0 >= 300);
    end
    check("cnt_wait", found, 1'b1);
    wait_idle("cnt_settle");
    status_reg = 8'h00;
`ifdef UART_POLL_ERR_CNT_EN
    check("cnt_parity",   err_parity,   8'd255);
    check("cnt_overflow", err_overflow, 8'd255);
    check("cnt_framing",  err_framing,  8'd255);
`else
    check("cnt_parity",   err_parity,   8'd0);
    check("cnt_overflow", err_overflow, 8'd0);
    check("cnt_framing",  err_framing,  8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
